// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sharing sequencer:
//   - default operand/opcode/counter widths
//   - sequencer state encoding (2-bit)
// ---------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int ALU_DATA_W = 8;   // operand and result width
   localparam int ALU_OP_W   = 4;   // opcode width
   localparam int ALU_CNT_W  = 16;  // completed-operation counter width

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } seq_state_t;

endpackage : alu_seq_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid[1:0]  in   request valids from requesters 0 and 1
//   last_grant  in   requester that owned the most recent completed operation
//   enable      in   arbitration allowed this cycle (sequencer idle)
//   grant[1:0]  out  one-hot grant, all zeros when disabled or no request
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         // On a tie, the requester that did not win last time is chosen.
         grant[0] = valid[0] & (~valid[1] | last_grant);
         grant[1] = valid[1] & (~valid[0] | ~last_grant);
      end
   end

endmodule : rr_arb2

// File: rtl/alu_share_sequencer.sv
// ---------------------------------------------------------------------------
// alu_share_sequencer
// Shares one combinational ALU between two requesters. A request is accepted
// with a valid/ready handshake in IDLE, its operands are registered onto the
// ALU inputs, the ALU gets one full EXEC cycle to settle, and the result is
// captured and held in RESP until the consumer acknowledges it.
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   reqN_valid/ready        request handshake for requester N (0 or 1)
//   reqN_a/b/op             operands and opcode of requester N
//   alu_a/alu_b/alu_op      registered ALU inputs (sole driver of the ALU)
//   alu_result              combinational ALU result
//   resp_valid/id/data      held response, owner id and captured result
//   resp_ack                consumer accepts the response (only in RESP)
//   busy                    sequencer is not idle
//   ops_done                count of acknowledged operations (wraps)
// ---------------------------------------------------------------------------
module alu_share_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W,
   parameter int CNT_W  = ALU_CNT_W
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,

   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,

   output logic              resp_valid,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_data,
   input  logic              resp_ack,

   output logic              busy,
   output logic [CNT_W-1:0]  ops_done
);

   seq_state_t        state_reg, state_next;
   logic              last_grant_reg;
   logic              grant_id_reg;
   logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
   logic [OP_W-1:0]   alu_op_reg;
   logic              resp_valid_reg;
   logic              resp_id_reg;
   logic [DATA_W-1:0] resp_data_reg;
   logic [CNT_W-1:0]  ops_done_reg;

   logic [1:0]        grant;
   logic              idle;

   assign idle = (state_reg == S_IDLE);

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_reg),
      .enable     (idle),
      .grant      (grant)
   );

   // The grant already includes the valid, so ready == grant is a handshake.
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (|grant)   state_next = S_EXEC;
         S_EXEC:               state_next = S_RESP;
         S_RESP: if (resp_ack) state_next = S_IDLE;
         default:              state_next = S_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         last_grant_reg <= 1'b1;     // requester 0 wins the first tie
         grant_id_reg   <= 1'b0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_op_reg     <= '0;
         resp_valid_reg <= 1'b0;
         resp_id_reg    <= 1'b0;
         resp_data_reg  <= '0;
         ops_done_reg   <= '0;
      end else begin
         state_reg <= state_next;

         // Operands are sampled only on the handshake cycle.
         if (grant[0]) begin
            alu_a_reg    <= req0_a;
            alu_b_reg    <= req0_b;
            alu_op_reg   <= req0_op;
            grant_id_reg <= 1'b0;
         end else if (grant[1]) begin
            alu_a_reg    <= req1_a;
            alu_b_reg    <= req1_b;
            alu_op_reg   <= req1_op;
            grant_id_reg <= 1'b1;
         end

         // The ALU inputs have been stable for the whole EXEC cycle.
         if (state_reg == S_EXEC) begin
            resp_data_reg  <= alu_result;
            resp_id_reg    <= grant_id_reg;
            resp_valid_reg <= 1'b1;
         end

         // Round-robin history only advances on completed operations, so
         // an aborted transaction does not affect fairness.
         if (state_reg == S_RESP && resp_ack) begin
            resp_valid_reg <= 1'b0;
            last_grant_reg <= grant_id_reg;
            ops_done_reg   <= ops_done_reg + CNT_W'(1);
         end
      end
   end

   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign alu_op     = alu_op_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_id    = resp_id_reg;
   assign resp_data  = resp_data_reg;
   assign ops_done   = ops_done_reg;
   assign busy       = ~idle;

endmodule : alu_share_sequencer

// File: tb/tb_alu_share_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_share_sequencer
// Directed bench for alu_share_sequencer. A behavioural ALU (op 0 = add,
// op 1 = subtract, modulo 256) sits behind the DUT. The counter width is
// reduced to 4 bits so the wrap of ops_done is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_alu_share_sequencer;

   localparam int DW  = 8;
   localparam int OW  = 4;
   localparam int CW  = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready;
   logic [DW-1:0] req0_a, req0_b;
   logic [OW-1:0] req0_op;
   logic          req1_valid, req1_ready;
   logic [DW-1:0] req1_a, req1_b;
   logic [OW-1:0] req1_op;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [OW-1:0] alu_op;
   logic          resp_valid, resp_id, resp_ack, busy;
   logic [DW-1:0] resp_data;
   logic [CW-1:0] ops_done;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   // Behavioural ALU
   always_comb begin
      case (alu_op)
         4'd0:    alu_result = alu_a + alu_b;
         4'd1:    alu_result = alu_a - alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   alu_share_sequencer #(.DATA_W(DW), .OP_W(OW), .CNT_W(CW)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_ack   (resp_ack),
      .busy       (busy),
      .ops_done   (ops_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   // Runs one operation from an IDLE cycle with requests already driven and
   // resp_ack high; requests stay as driven.
   task automatic run_op(input string tag, input logic exp_id, input logic [7:0] exp_data);
      #1;
      check({tag, ".ready0"}, 32'(req0_ready), 32'(exp_id == 1'b0));
      check({tag, ".ready1"}, 32'(req1_ready), 32'(exp_id == 1'b1));
      tick();
      check({tag, ".busy_exec"}, 32'(busy), 32'd1);
      tick();
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".resp_id"}, 32'(resp_id), 32'(exp_id));
      check({tag, ".resp_data"}, 32'(resp_data), 32'(exp_data));
      tick();
      check({tag, ".resp_clear"}, 32'(resp_valid), 32'd0);
      $display("op %s id=%0d data=%0h ops_done=%0d", tag, resp_id, resp_data, ops_done);
   endtask

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      resp_ack   = 1'b0;

      // ---------------- reset state
      tick();
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_id", 32'(resp_id), 32'd0);
      check("rst.resp_data", 32'(resp_data), 32'd0);
      check("rst.alu_a", 32'(alu_a), 32'd0);
      check("rst.ops_done", 32'(ops_done), 32'd0);
      reset = 1'b0;

      // ---------------- 1: single request, immediate ack
      tick();
      req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd3; req0_op = 4'd0;
      resp_ack = 1'b1;
      #1;
      check("t1.ready0", 32'(req0_ready), 32'd1);
      check("t1.ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      check("t1.alu_a", 32'(alu_a), 32'd2);
      check("t1.alu_b", 32'(alu_b), 32'd3);
      check("t1.exec_resp_valid", 32'(resp_valid), 32'd0);
      check("t1.ready_in_exec", 32'(req0_ready), 32'd0);
      tick();
      check("t1.resp_valid", 32'(resp_valid), 32'd1);
      check("t1.resp_id", 32'(resp_id), 32'd0);
      check("t1.resp_data", 32'(resp_data), 32'd5);
      tick();
      check("t1.ops_done", 32'(ops_done), 32'd1);
      check("t1.idle", 32'(busy), 32'd0);
      check("t1.resp_clear", 32'(resp_valid), 32'd0);
      $display("op t1 id=%0d data=%0h ops_done=%0d", resp_id, resp_data, ops_done);

      // ---------------- 2: both requesters valid, alternating grants
      pulse_reset();
      req0_valid = 1'b1; req0_a = 8'd2;  req0_b = 8'd3; req0_op = 4'd1;
      req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd4; req1_op = 4'd0;
      run_op("t2.op0", 1'b0, 8'hFF);
      run_op("t2.op1", 1'b1, 8'd14);
      run_op("t2.op2", 1'b0, 8'hFF);
      run_op("t2.op3", 1'b1, 8'd14);
      check("t2.ops_done", 32'(ops_done), 32'd4);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // ---------------- 3: ack withheld in RESP while req1 waits
      req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd1; req0_op = 4'd1;
      resp_ack = 1'b0;
      #1;
      check("t3.ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6; req1_op = 4'd0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t3.hold_valid", 32'(resp_valid), 32'd1);
         check("t3.hold_data", 32'(resp_data), 32'd6);
         check("t3.hold_alu_a", 32'(alu_a), 32'd7);
         check("t3.hold_ready1", 32'(req1_ready), 32'd0);
         tick();
      end
      resp_ack = 1'b1;
      tick();
      check("t3.release_ready1", 32'(req1_ready), 32'd1);
      check("t3.release_valid", 32'(resp_valid), 32'd0);
      tick();
      req1_valid = 1'b0;
      #1;
      check("t3.alu_a_req1", 32'(alu_a), 32'd5);
      tick();
      check("t3.resp_id", 32'(resp_id), 32'd1);
      check("t3.resp_data", 32'(resp_data), 32'd11);
      tick();
      $display("op t3 id=%0d data=%0h ops_done=%0d", resp_id, resp_data, ops_done);

      // ---------------- 4: reset during EXEC
      req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_op = 4'd0;
      run_op("t4.pre", 1'b0, 8'd2);       // last_grant becomes 0
      req0_a = 8'd9; req0_b = 8'd9;
      tick();                             // accepted, now in EXEC
      req0_valid = 1'b0;
      check("t4.in_exec", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("t4.busy", 32'(busy), 32'd0);
      check("t4.alu_a", 32'(alu_a), 32'd0);
      check("t4.alu_b", 32'(alu_b), 32'd0);
      check("t4.resp_data", 32'(resp_data), 32'd0);
      check("t4.ops_done", 32'(ops_done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4.no_resp", 32'(resp_valid), 32'd0);
      end
      req0_valid = 1'b1; req0_a = 8'd4; req0_b = 8'd4; req0_op = 4'd1;
      req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd3; req1_op = 4'd0;
      run_op("t4.tie", 1'b0, 8'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // ---------------- 6: req0 pulsed during RESP is never accepted
      req1_valid = 1'b1; req1_a = 8'd20; req1_b = 8'd5; req1_op = 4'd1;
      resp_ack = 1'b0;
      tick();
      req1_valid = 1'b0;
      tick();
      check("t6.resp_valid", 32'(resp_valid), 32'd1);
      req0_valid = 1'b1; req0_a = 8'd33; req0_b = 8'd1; req0_op = 4'd0;
      #1;
      check("t6.ready0_resp", 32'(req0_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      resp_ack = 1'b1;
      check("t6.resp_data", 32'(resp_data), 32'd15);
      check("t6.resp_id", 32'(resp_id), 32'd1);
      tick();
      resp_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6.stay_idle", 32'(busy), 32'd0);
         check("t6.no_resp", 32'(resp_valid), 32'd0);
      end
      check("t6.alu_a_unchanged", 32'(alu_a), 32'd20);
      $display("op t6 id=%0d data=%0h ops_done=%0d", resp_id, resp_data, ops_done);

      // ---------------- 5: ops_done wraps
      pulse_reset();
      resp_ack = 1'b1;
      req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 4'd0;
      for (int i = 0; i < 15; i++) run_op("t5.fill", 1'b0, 8'd3);
      check("t5.ops_done_max", 32'(ops_done), 32'd15);
      run_op("t5.wrap_op", 1'b0, 8'd3);
      check("t5.ops_done_wrap", 32'(ops_done), 32'd0);
      req0_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the bench cannot hang.
   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule : tb_alu_share_sequencer
